// File: rtl/edge_event_bank_pkg.sv
// Shared definitions for the edge event bank.
// Holds the per-channel event mode encoding and the helper that sizes the
// glitch-filter counter from the requested filter length.
package edge_event_bank_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold values up to FILTER_CYCLES-1; the +1 keeps the
    // width at least one bit when FILTER_CYCLES is 1.
    function automatic int filter_cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One channel of the edge event bank: synchroniser, glitch filter,
// rising/falling pulse generation and sticky pending/overrun flags.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   d        in   raw input, asynchronous to clk
//   mode     in   event mode (off / rise / fall / both)
//   clr      in   clear for pending and overrun
//   level    out  filtered level
//   up       out  one-cycle pulse on filtered rising edge
//   down     out  one-cycle pulse on filtered falling edge
//   pending  out  sticky: enabled event seen
//   overrun  out  sticky: enabled event seen while pending already set
module edge_event_channel
    import edge_event_bank_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       up,
    output logic       down,
    output logic       pending,
    output logic       overrun
);

    localparam int             CW       = filter_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   up_q, down_q;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic                   s;
    logic                   ev;
    logic                   rise_en, fall_en;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);
    assign ev      = (up_q & rise_en) | (down_q & fall_en);

    // Set dominates clear so an event arriving with clr is never dropped.
    assign pending_d = ev | (pending_q & ~clr);
    assign overrun_d = (ev & pending_q) | (overrun_q & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q     <= '0;
            level_q   <= INIT_LEVEL;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], d};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            up_q      <= level_d & ~level_q;
            down_q    <= ~level_d & level_q;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign level   = level_q;
    assign up      = up_q;
    assign down    = down_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/edge_event_bank.sv
// Multi-channel edge event bank: WIDTH independent edge_event_channel
// instances plus an interrupt line that is the OR of all pending flags.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   d        in   [WIDTH]    raw inputs, asynchronous to clk
//   mode     in   [2*WIDTH]  per-channel mode, channel i uses mode[2i+1:2i]
//   clr      in   [WIDTH]    per-channel clear of pending/overrun
//   level    out  [WIDTH]    filtered levels
//   up       out  [WIDTH]    rising-edge pulses
//   down     out  [WIDTH]    falling-edge pulses
//   pending  out  [WIDTH]    sticky event flags
//   overrun  out  [WIDTH]    sticky overrun flags
//   irq      out             OR of pending
module edge_event_bank
    import edge_event_bank_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_LEVEL    = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     d,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     up,
    output logic [WIDTH-1:0]     down,
    output logic [WIDTH-1:0]     pending,
    output logic [WIDTH-1:0]     overrun,
    output logic                 irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_event_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .INIT_LEVEL    (INIT_LEVEL[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .d       (d[i]),
            .mode    (mode[2*i +: 2]),
            .clr     (clr[i]),
            .level   (level[i]),
            .up      (up[i]),
            .down    (down[i]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    assign irq = |pending;

endmodule

// File: tb/tb_edge_event_bank.sv
module tb_edge_event_bank;

    localparam int              WIDTH = 8;
    localparam int              SYNC  = 2;
    localparam int              FC    = 4;
    localparam logic [WIDTH-1:0] INIT = 8'h0F;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     d;
    logic [2*WIDTH-1:0]   mode;
    logic [WIDTH-1:0]     clr;
    logic [WIDTH-1:0]     level, up, down, pending, overrun;
    logic                 irq;

    int n_pass  = 0;
    int n_total = 0;

    edge_event_bank #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FC),
        .INIT_LEVEL    (INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .mode    (mode),
        .clr     (clr),
        .level   (level),
        .up      (up),
        .down    (down),
        .pending (pending),
        .overrun (overrun),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: s is d delayed by SYNC sampling edges; level flips
    // once s has disagreed with it for FC consecutive samples.
    logic [WIDTH-1:0] q_sync[$];
    logic [WIDTH-1:0] m_level, m_up, m_down, m_pend, m_ovr;
    int               run[WIDTH];

    task automatic model_reset();
        q_sync.delete();
        repeat (SYNC) q_sync.push_back(INIT);
        m_level = INIT;
        m_up = '0; m_down = '0; m_pend = '0; m_ovr = '0;
        for (int i = 0; i < WIDTH; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] s_prev, lvl_new, ev;
        if (rst) begin
            model_reset();
        end else begin
            s_prev = q_sync[0];
            void'(q_sync.pop_front());
            q_sync.push_back(d);
            for (int i = 0; i < WIDTH; i++)
                ev[i] = (m_up[i] && mode[2*i]) || (m_down[i] && mode[2*i+1]);
            m_ovr  = (ev & m_pend) | (m_ovr & ~clr);
            m_pend = ev | (m_pend & ~clr);
            lvl_new = m_level;
            for (int i = 0; i < WIDTH; i++) begin
                if (s_prev[i] != m_level[i]) begin
                    run[i]++;
                    if (run[i] == FC) begin
                        lvl_new[i] = s_prev[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_up    = lvl_new & ~m_level;
            m_down  = ~lvl_new & m_level;
            m_level = lvl_new;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("m_level",   level,   m_level);
        chk("m_up",      up,      m_up);
        chk("m_down",    down,    m_down);
        chk("m_pending", pending, m_pend);
        chk("m_overrun", overrun, m_ovr);
        chk("m_irq",     irq,     |m_pend);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic saw_up, saw_down, saw_up3, found;
        model_reset();
        rst = 1'b1; d = '0; mode = '0; clr = '0;

        // Reset and init level
        repeat (3) step();
        chk("rst_level",   level,   8'h0F);
        chk("rst_up",      up,      8'h00);
        chk("rst_down",    down,    8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_overrun", overrun, 8'h00);
        chk("rst_irq",     irq,     1'b0);
        rst = 1'b0; d = 8'h0F;
        saw_up = 1'b0; saw_down = 1'b0;
        repeat (10) begin
            step();
            saw_up   = saw_up   | (|up);
            saw_down = saw_down | (|down);
        end
        chk("init_no_up",   saw_up,   1'b0);
        chk("init_no_down", saw_down, 1'b0);

        // Bring every channel low with events disabled
        d = '0;
        repeat (10) step();
        chk("all_low", level, 8'h00);

        // Latency on ch0, all channels rise-mode
        mode = 16'h5555;
        d[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("lat_up0_e%0d", k),    up[0],      k == 6);
            chk($sformatf("lat_lvl0_e%0d", k),   level[0],   k >= 6);
            chk($sformatf("lat_pend0_e%0d", k),  pending[0], k >= 7);
            chk($sformatf("lat_irq_e%0d", k),    irq,        k >= 7);
        end
        clr = '1; step(); clr = '0;

        // Glitch of 3 samples on ch1 is rejected
        d[1] = 1'b1;
        repeat (3) step();
        d[1] = 1'b0;
        repeat (8) begin
            step();
            chk("glitch_lvl1",  level[1],   1'b0);
            chk("glitch_up1",   up[1],      1'b0);
            chk("glitch_pend1", pending[1], 1'b0);
        end
        // 4 samples qualify
        d[1] = 1'b1;
        repeat (4) step();
        d[1] = 1'b0;
        saw_up = 1'b0; saw_down = 1'b0;
        repeat (12) begin
            step();
            saw_up   = saw_up   | up[1];
            saw_down = saw_down | down[1];
        end
        chk("q4_up1",   saw_up,     1'b1);
        chk("q4_down1", saw_down,   1'b1);
        chk("q4_pend1", pending[1], 1'b1);
        clr = '1; step(); clr = '0;

        // Mode: ch2 fall-only, ch3 off
        mode = 16'h5525;
        saw_up = 1'b0; saw_down = 1'b0; saw_up3 = 1'b0;
        d[3:2] = 2'b11;
        repeat (10) begin
            step();
            saw_up  = saw_up  | up[2];
            saw_up3 = saw_up3 | up[3];
        end
        chk("mode_pend2_after_rise", pending[2], 1'b0);
        d[3:2] = 2'b00;
        repeat (10) begin
            step();
            saw_down = saw_down | down[2];
        end
        chk("mode_up2",    saw_up,     1'b1);
        chk("mode_down2",  saw_down,   1'b1);
        chk("mode_pend2",  pending[2], 1'b1);
        chk("mode_up3",    saw_up3,    1'b1);
        chk("mode_pend3",  pending[3], 1'b0);

        // Overrun and clear on ch4
        d[4] = 1'b1; repeat (10) step();
        d[4] = 1'b0; repeat (10) step();
        d[4] = 1'b1; repeat (10) step();
        chk("ovr_pend4", pending[4], 1'b1);
        chk("ovr_ovr4",  overrun[4], 1'b1);
        clr[4] = 1'b1; step(); clr[4] = 1'b0;
        chk("clr_pend4", pending[4], 1'b0);
        chk("clr_ovr4",  overrun[4], 1'b0);
        d[4] = 1'b0; repeat (10) step();
        d[4] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = up[4];
        end
        chk("clr_up4_seen", found, 1'b1);
        clr[4] = 1'b1; step(); clr[4] = 1'b0;
        chk("setwins_pend4", pending[4], 1'b1);
        chk("setwins_ovr4",  overrun[4], 1'b0);
        clr = '1; step(); clr = '0;

        // Reset while ch5 filter count is 2
        d[5] = 1'b1;
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_lvl5", level[5], 1'b0);
        chk("midrst_up5",  up[5],    1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("requal_up5_e%0d", k),  up[5],    k == 6);
            chk($sformatf("requal_lvl5_e%0d", k), level[5], k >= 6);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < WIDTH; i++)
                if ($urandom_range(5) == 0) d[i] = ~d[i];
            if ($urandom_range(49) == 0) mode = 16'($urandom);
            clr = 8'($urandom & $urandom & $urandom);
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
